// File: rtl/n2p_port_tx.sv
// Read-side controller for the node-to-port FIFO: hides the FIFO's registered read latency and frames flits onto a valid/ready link.
// Optional statistics counters (pkt_cnt, drop_cnt) are built when N2P_TX_STATS_EN is defined.
module n2p_port_tx #(
  parameter int DATA_WIDTH = 9,
  parameter int LEN_WIDTH  = 4,
  parameter int STAT_WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    fifo_empty,
  input  logic [DATA_WIDTH-1:0]   fifo_data,
  output logic                    fifo_rd_en,
  output logic                    tx_valid,
  input  logic                    tx_ready,
  output logic [DATA_WIDTH-2:0]   tx_data,
  output logic                    tx_sop,
  output logic                    tx_eop,
  output logic                    framing_err
`ifdef N2P_TX_STATS_EN
  ,
  output logic [STAT_WIDTH-1:0]   pkt_cnt,
  output logic [STAT_WIDTH-1:0]   drop_cnt
`endif
);

  typedef enum logic {
    IDLE,
    PAYLOAD
  } state_t;

  state_t                state;
  logic [LEN_WIDTH-1:0]  rem;
  logic [1:0]            occ;
  logic                  inflight_p1;
  logic [DATA_WIDTH-1:0] buf_p2 [2];

  logic [DATA_WIDTH-1:0] head;
  logic                  head_hdr;
  logic [LEN_WIDTH-1:0]  head_len;
  logic                  has_head;
  logic                  drop;
  logic                  accept;
  logic                  pop;
  logic                  rem_is_one;
  logic [2:0]            backlog;
  logic [2:0]            room;

  assign head       = buf_p2[0];
  assign head_hdr   = head[DATA_WIDTH-1];
  assign head_len   = head[LEN_WIDTH-1:0];
  assign has_head   = (occ != 2'd0);
  assign rem_is_one = (rem == LEN_WIDTH'(1));

  // A payload flit reaching the head while idle belongs to no packet: discard it in place.
  assign drop     = has_head && (state == IDLE) && !head_hdr;
  assign tx_valid = has_head && !drop;
  assign accept   = tx_valid && tx_ready;
  assign pop      = accept || drop;

  assign tx_data     = tx_valid ? head[DATA_WIDTH-2:0] : '0;
  assign tx_sop      = tx_valid && head_hdr;
  assign tx_eop      = tx_valid && (head_hdr ? (head_len == '0) : rem_is_one);
  assign framing_err = drop || (accept && (state == PAYLOAD) && head_hdr);

  // Entries already buffered or arriving next edge, less the one leaving now, must leave a free slot.
  assign backlog    = {1'b0, occ} + {2'b00, inflight_p1};
  assign room       = 3'd2 + {2'b00, pop};
  assign fifo_rd_en = rst_n && !fifo_empty && (backlog < room);

  // Stage p1: read issued last cycle, data present on fifo_data now
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight_p1 <= 1'b0;
      occ         <= 2'd0;
    end else begin
      inflight_p1 <= fifo_rd_en;
      case ({inflight_p1, pop})
        2'b10:   occ <= occ + 2'd1;
        2'b01:   occ <= occ - 2'd1;
        default: occ <= occ;
      endcase
    end
  end

  // Stage p2: two-entry output buffer, slot 0 is the head
  always_ff @(posedge clk) begin
    if (pop) begin
      if (inflight_p1 && (occ == 2'd1)) begin
        buf_p2[0] <= fifo_data;
      end else begin
        buf_p2[0] <= buf_p2[1];
      end
      if (inflight_p1 && (occ == 2'd2)) begin
        buf_p2[1] <= fifo_data;
      end
    end else if (inflight_p1) begin
      if (occ == 2'd0) begin
        buf_p2[0] <= fifo_data;
      end else begin
        buf_p2[1] <= fifo_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      rem   <= '0;
    end else if (accept) begin
      if (head_hdr) begin
        rem   <= head_len;
        state <= (head_len != '0) ? PAYLOAD : IDLE;
      end else if (rem != '0) begin
        rem <= rem - LEN_WIDTH'(1);
        if (rem_is_one) begin
          state <= IDLE;
        end
      end
    end
  end

`ifdef N2P_TX_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pkt_cnt  <= '0;
      drop_cnt <= '0;
    end else begin
      if (accept && tx_eop && (pkt_cnt != '1)) begin
        pkt_cnt <= pkt_cnt + STAT_WIDTH'(1);
      end
      if (drop && (drop_cnt != '1)) begin
        drop_cnt <= drop_cnt + STAT_WIDTH'(1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_n2p_port_tx.sv
// Randomized bench for n2p_port_tx: a queue-based FIFO model feeds the DUT and a packet-level model predicts the link stream.
module tb_n2p_port_tx;
  localparam int DW = 9;
  localparam int SW = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          fifo_empty;
  logic [DW-1:0] fifo_data;
  logic          fifo_rd_en;
  logic          tx_valid;
  logic          tx_ready;
  logic [DW-2:0] tx_data;
  logic          tx_sop;
  logic          tx_eop;
  logic          framing_err;
`ifdef N2P_TX_STATS_EN
  logic [SW-1:0] pkt_cnt;
  logic [SW-1:0] drop_cnt;
`endif

  always #5 clk = ~clk;

  n2p_port_tx dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .fifo_empty  (fifo_empty),
    .fifo_data   (fifo_data),
    .fifo_rd_en  (fifo_rd_en),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .tx_data     (tx_data),
    .tx_sop      (tx_sop),
    .tx_eop      (tx_eop),
`ifdef N2P_TX_STATS_EN
    .pkt_cnt     (pkt_cnt),
    .drop_cnt    (drop_cnt),
`endif
    .framing_err (framing_err)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // FIFO contents and expected link stream {err, sop, eop, data}
  logic [DW-1:0] fq[$];
  logic [10:0]   exp_q[$];
  bit            m_pay;
  int            m_rem;
  int            exp_drops, obs_drops;
  int            exp_pkts_total, exp_drops_total;

  int            outstanding;
  bit            rd_prev;
  bit            prev_stall;
  logic [9:0]    prev_flit;
  bit            force_stall;
  bit            rand_ready;
  int            cyc_n;
  int            first_rd, first_vld, acc_first, acc_last;

  task automatic model_clear();
    fq.delete();
    exp_q.delete();
    m_pay = 1'b0;
    m_rem = 0;
    exp_drops = 0;
    obs_drops = 0;
    exp_pkts_total = 0;
    exp_drops_total = 0;
    outstanding = 0;
    rd_prev = 1'b0;
    prev_stall = 1'b0;
  endtask

  task automatic push_entry(input logic [DW-1:0] e);
    bit       hdr;
    int       len;
    bit       eop;
    hdr = e[DW-1];
    len = int'(e[3:0]);
    fq.push_back(e);
    if (!m_pay) begin
      if (!hdr) begin
        exp_drops++;
        exp_drops_total++;
      end else begin
        eop = (len == 0);
        exp_q.push_back({1'b0, 1'b1, eop, e[7:0]});
        exp_pkts_total += int'(eop);
        if (len != 0) begin
          m_pay = 1'b1;
          m_rem = len;
        end
      end
    end else if (hdr) begin
      eop = (len == 0);
      exp_q.push_back({1'b1, 1'b1, eop, e[7:0]});
      exp_pkts_total += int'(eop);
      m_rem = len;
      m_pay = (len != 0);
    end else begin
      m_rem--;
      eop = (m_rem == 0);
      exp_q.push_back({1'b0, 1'b0, eop, e[7:0]});
      exp_pkts_total += int'(eop);
      if (m_rem == 0) m_pay = 1'b0;
    end
  endtask

  task automatic cyc();
    bit         pop_now;
    bit         exp_rd;
    logic [10:0] obs;
    @(posedge clk);
    #1;
    cyc_n++;
    if (rd_prev && fq.size() != 0) fifo_data = fq.pop_front();
    fifo_empty = (fq.size() == 0);
    tx_ready = force_stall ? 1'b0 : (rand_ready ? 1'($urandom_range(0, 1)) : 1'b1);
    #1;
    pop_now = (tx_valid && tx_ready) || (framing_err && !tx_valid);
    exp_rd  = !fifo_empty && ((outstanding - int'(pop_now)) < 2);
    check("rd_en", 32'(fifo_rd_en), 32'(exp_rd));
    if (prev_stall) begin
      check("hold_valid", 32'(tx_valid), 32'd1);
      check("hold_flit", 32'({tx_sop, tx_eop, tx_data}), 32'(prev_flit));
    end
    if (framing_err && tx_valid) check("err_without_accept", 32'(tx_ready), 32'd1);
    if (tx_valid && tx_ready) begin
      obs = {framing_err, tx_sop, tx_eop, tx_data};
      if (exp_q.size() == 0) check("unexpected_flit", 32'(exp_q.size()), 32'd1);
      else check("flit", 32'(obs), 32'(exp_q.pop_front()));
      if (acc_first < 0) acc_first = cyc_n;
      acc_last = cyc_n;
    end
    if (framing_err && !tx_valid) obs_drops++;
    if (fifo_rd_en && first_rd < 0) first_rd = cyc_n;
    if (tx_valid && first_vld < 0) first_vld = cyc_n;
    outstanding += int'(fifo_rd_en) - int'(pop_now);
    rd_prev    = fifo_rd_en;
    prev_stall = tx_valid && !tx_ready;
    prev_flit  = {tx_sop, tx_eop, tx_data};
  endtask

  task automatic drain(input string tag, input int bound);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || fq.size() != 0 || outstanding != 0) && n < bound) begin
      cyc();
      n++;
    end
    check({tag, "_left"}, 32'(exp_q.size() + fq.size() + outstanding), 32'd0);
    check({tag, "_drops"}, 32'(obs_drops), 32'(exp_drops));
    obs_drops = 0;
    exp_drops = 0;
  endtask

  task automatic wait_valid(input string tag);
    for (int n = 0; n < 10; n++) begin
      cyc();
      if (tx_valid) break;
    end
    check({tag, "_wait_valid"}, 32'(tx_valid), 32'd1);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_rd_en"}, 32'(fifo_rd_en), 32'd0);
    check({tag, "_valid"}, 32'(tx_valid), 32'd0);
    check({tag, "_data"}, 32'(tx_data), 32'd0);
    check({tag, "_sop"}, 32'(tx_sop), 32'd0);
    check({tag, "_eop"}, 32'(tx_eop), 32'd0);
    check({tag, "_err"}, 32'(framing_err), 32'd0);
`ifdef N2P_TX_STATS_EN
    check({tag, "_pkt_cnt"}, 32'(pkt_cnt), 32'd0);
    check({tag, "_drop_cnt"}, 32'(drop_cnt), 32'd0);
`endif
  endtask

  task automatic check_stats(input string tag);
`ifdef N2P_TX_STATS_EN
    check({tag, "_pkt_cnt"}, 32'(pkt_cnt), 32'(exp_pkts_total));
    check({tag, "_drop_cnt"}, 32'(drop_cnt), 32'(exp_drops_total));
`else
    n_checks += 0;
`endif
  endtask

  initial begin
    logic [DW-1:0] e;
    logic [3:0]    hi;
    int            r, len, npay;

    rst_n = 1'b0;
    fifo_empty = 1'b0;
    fifo_data = 9'h1FF;
    tx_ready = 1'b1;
    force_stall = 1'b0;
    rand_ready = 1'b0;
    cyc_n = 0;
    model_clear();

    // Reset held with a non-empty FIFO
    repeat (3) @(posedge clk);
    #2;
    check_idle_outputs("reset_hold");
    fifo_empty = 1'b1;
    rst_n = 1'b1;

    // Asynchronous reset in the middle of a packet
    push_entry(9'h103);
    push_entry(9'h011);
    push_entry(9'h022);
    push_entry(9'h033);
    wait_valid("midrst");
    cyc();
    check("midrst_pre_valid", 32'(tx_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    check_idle_outputs("midrst");
    model_clear();
    fifo_empty = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b1;

    // Basic packet, full-rate sink: latency and back-to-back delivery
    first_rd = -1; first_vld = -1; acc_first = -1; acc_last = -1;
    push_entry(9'h102);
    push_entry(9'h0AA);
    push_entry(9'h0BB);
    drain("basic", 30);
    check("latency", 32'(first_vld - first_rd), 32'd2);
    check("back_to_back", 32'(acc_last - acc_first), 32'd2);

    // Same packet, sink stalled on the first flit
    force_stall = 1'b1;
    push_entry(9'h102);
    push_entry(9'h0AA);
    push_entry(9'h0BB);
    wait_valid("stall");
    for (int i = 0; i < 5; i++) begin
      check("stall_data", 32'(tx_data), 32'h02);
      check("stall_sop", 32'(tx_sop), 32'd1);
      cyc();
    end
    check("stall_backlog", 32'(outstanding), 32'd2);
    force_stall = 1'b0;
    drain("stall", 30);

    // Zero-length packet, then a stray payload that must be dropped in IDLE
    push_entry(9'h100);
    drain("zero_len", 30);
    push_entry(9'h055);
    push_entry(9'h101);
    push_entry(9'h033);
    drain("stray", 30);

    // Truncated packet interrupted by an early header, then a stray proving IDLE
    push_entry(9'h103);
    push_entry(9'h011);
    push_entry(9'h100);
    push_entry(9'h077);
    drain("early_hdr", 30);
    check_stats("directed");

    // Random traffic with random back-pressure, strays and truncated packets
    rand_ready = 1'b1;
    for (int p = 0; p < 80; p++) begin
      r = $urandom_range(0, 9);
      if (r == 0) begin
        e = {1'b0, 8'($urandom)};
        push_entry(e);
      end else begin
        len = (r == 1) ? $urandom_range(0, 15) : $urandom_range(0, 4);
        hi = 4'($urandom);
        e = {1'b1, hi, 4'(len)};
        push_entry(e);
        npay = (r == 2) ? $urandom_range(0, len) : len;
        for (int k = 0; k < npay; k++) begin
          e = {1'b0, 8'($urandom)};
          push_entry(e);
        end
      end
    end
    drain("random", 4000);
    check_stats("random");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/n2p_port_tx.md
Name: n2p_port_tx

Overview:
Read-side controller for the node-to-port FIFO in the NOC switch. It pops 9-bit flit entries from the FIFO, absorbing the FIFO's one-cycle registered read latency in a 2-entry output buffer. It tracks packet framing and drives a valid/ready link toward the output port with start/end-of-packet markers. The FIFO's active-high reset is driven from the inverse of rst_n at the top level.

Parameters:
DATA_WIDTH, 9, FIFO entry width; the MSB is the header flag and the lower DATA_WIDTH-1 bits are payload.
LEN_WIDTH, 4, width of the length field in header bits [LEN_WIDTH-1:0]; it gives the number of payload flits that follow (0..15).
STAT_WIDTH, 16, width of the statistics counters (used only with the optional feature).

Ports:
clk  input  1  clock; all logic is on the rising edge.
rst_n  input  1  asynchronous active-low reset.
fifo_empty  input  1  FIFO empty flag.
fifo_data  input  DATA_WIDTH  FIFO data_out; valid in the cycle after fifo_rd_en.
fifo_rd_en  output  1  FIFO read enable (combinational).
tx_valid  output  1  link flit valid.
tx_ready  input  1  port accepts the flit.
tx_data  output  DATA_WIDTH-1  flit payload (header flag stripped).
tx_sop  output  1  flit is a packet header.
tx_eop  output  1  flit is the last flit of the packet.
framing_err  output  1  one-cycle pulse on a framing violation.

Behaviour:
- Reset (rst_n low, asynchronous): buffer empty, in-flight flag 0, FSM IDLE, remaining count 0.
  - All outputs 0: tx_valid, tx_data, tx_sop, tx_eop, framing_err, stats.
  - fifo_rd_en is forced 0 while rst_n is low.
  - A read in flight when reset asserts is discarded. The FIFO is reset in the same event.
- Read issue:
  - fifo_rd_en = !fifo_empty && (occ + inflight - pop) < 2.
  - occ: buffer occupancy, 0..2. inflight: rd_en was issued last cycle. pop: tx_valid && tx_ready, or a drop (see below) this cycle.
  - fifo_rd_en is never asserted when fifo_empty=1, because the FIFO advances its pointer unconditionally.
- Capture: when inflight=1, fifo_data is written into the buffer tail at the end of that cycle.
- Latency: a flit is on tx_valid 2 cycles after its fifo_rd_en cycle.
- Throughput: 1 flit/cycle sustained with tx_ready held high.
- Link handshake:
  - tx_valid stays high until accepted.
  - tx_data, tx_sop and tx_eop are stable while tx_valid && !tx_ready.
  - The buffer head pops on tx_valid && tx_ready.
- Framing FSM, evaluated on the buffer head:
  - IDLE, head flag=1 (header): tx_sop=1 and tx_eop=(len==0). On accept, load rem=len; go to PAYLOAD if len!=0, otherwise stay IDLE.
  - IDLE, head flag=0 (stray payload): not presented (tx_valid=0). The flit is popped in one cycle and framing_err pulses.
  - PAYLOAD, flag=0: tx_sop=0 and tx_eop=(rem==1). On accept, rem decrements; rem 1->0 returns to IDLE.
  - PAYLOAD, flag=1 (early header): framing_err pulses when the flit is accepted. The flit is sent as a new header (sop=1), rem is reloaded, and the previous packet is left without an eop.
- rem is LEN_WIDTH bits and never wraps: it decrements only when rem is at least 1.
- Simultaneous capture and pop in the same cycle: occupancy is unchanged and ordering is preserved.

Optional Feature:
N2P_TX_STATS_EN.
- When defined, adds two outputs: pkt_cnt[STAT_WIDTH-1:0] and drop_cnt[STAT_WIDTH-1:0].
  - pkt_cnt increments on each accepted flit with tx_eop=1.
  - drop_cnt increments on each stray-payload drop.
  - Both saturate at all-ones and reset to 0.
- When undefined, these ports and counters do not exist, and all other behaviour is identical.

Test Plan:
1. Hold rst_n=0 with fifo_empty=0 -> fifo_rd_en=0 and all outputs 0. Assert rst_n low mid-packet -> outputs clear immediately, without waiting for a clock edge.
2. FIFO holds 0x102, 0x0AA, 0x0BB; tx_ready=1 -> tx_data 0x02 (sop), 0xAA, 0xBB (eop) on 3 consecutive cycles; first tx_valid 2 cycles after the first fifo_rd_en.
3. Same packet with tx_ready=0 for 5 cycles after the first tx_valid -> tx_data held at 0x02; fifo_rd_en stops once 2 flits are buffered or in flight; all 3 flits delivered in order, none lost.
4. Header 0x100 -> single flit 0x00 with tx_sop=1 and tx_eop=1; FSM stays IDLE; pkt_cnt=1 with N2P_TX_STATS_EN.
5. Stray 0x055 in IDLE followed by header 0x101 and payload 0x033 -> 0x55 never on tx_valid; framing_err pulses exactly 1 cycle; drop_cnt=1; 0x01 (sop) and 0x33 (eop) then delivered.
6. Header 0x103, payload 0x011, then header 0x100 -> framing_err pulses when 0x00 is accepted; 0x00 is sent with sop=1 and eop=1; FSM returns to IDLE.
